// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add/sub pipeline.
// Width-dependent stage payloads live in fp_addsub_pipe; this package holds the width-free parts.
package fp_pkg;

  localparam int FP_EXP_W = 5;
  localparam int FP_MAN_W = 10;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  typedef struct packed {
    logic nan;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  // Canonical quiet NaN {0, all-ones, 1, zeros}; callers slice the low exp_w+man_w+1 bits.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns WIDTH when the input is all zero.
module fp_lzc #(
  parameter int WIDTH = 14,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Scan upward so the highest set bit is the last writer.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Five-stage floating-point adder/subtractor with IEEE specials, status flags and valid/ready.
// FP_ROUND_RNE_EN selects round-to-nearest-even; otherwise results are truncated and overflow saturates.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int  EXP_W = FP_EXP_W,
  parameter int  MAN_W = FP_MAN_W,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         busy
);

  localparam int                M          = MAN_W + 4;
  localparam int                LZ_W       = $clog2(M + 1);
  localparam logic [EXP_W-1:0]  EXP_ONES   = '1;
  localparam logic [EXP_W-1:0]  EXP_MAX    = EXP_ONES - EXP_W'(1);
  localparam logic [63:0]       QNAN_WIDE  = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]      QNAN       = QNAN_WIDE[W-1:0];

  typedef struct packed { logic s; logic [EXP_W-1:0] e; logic [MAN_W-1:0] f; fp_class_t c; } opnd_t;
  typedef struct packed { logic en; logic nan; logic [W-1:0] res; } spec_t;
  typedef struct packed { logic s; logic [EXP_W:0] e; logic [M-1:0] mx; logic [M-1:0] my; logic sub; spec_t sp; } s2_t;
  typedef struct packed { logic s; logic [EXP_W:0] e; logic [M:0] sum; spec_t sp; } s3_t;
  typedef struct packed { logic s; logic [EXP_W:0] e; logic [M-1:0] n; logic zero; logic unf; spec_t sp; } s4_t;

  // Handshake: a beat moves on every edge where ready_out is high; ready_out = !valid_out || ready_in,
  // so the whole pipe advances or freezes together and a stalled output holds result/flags stable.
  logic      w_adv;
  logic [4:0] r_v;
  opnd_t     r_a1, r_b1;
  s2_t       r_s2, w_s2;
  s3_t       r_s3, w_s3;
  s4_t       r_s4, w_s4;
  logic [W-1:0] r_res5, w_res5;
  fp_flags_t r_flg5, w_flg5;

  assign w_adv     = !r_v[4] || ready_in;
  assign ready_out = w_adv;
  assign valid_out = r_v[4];
  assign busy      = |r_v;
  assign result    = r_v[4] ? r_res5 : '0;
  assign flags     = r_v[4] ? r_flg5 : '0;

  function automatic opnd_t unpack(input logic [W-1:0] v, input logic flip);
    opnd_t o;
    o.s = v[W-1] ^ flip;
    o.e = v[W-2:MAN_W];
    o.f = v[MAN_W-1:0];
    if (o.e == '0)            o.c = ZERO;
    else if (o.e == EXP_ONES) o.c = (o.f == '0) ? INF : NAN;
    else                      o.c = NORM;
    return o;
  endfunction

  // Stage 2: order by magnitude, align the smaller mantissa, resolve specials.
  logic                 w_a_ge, w_x_s, w_y_s;
  logic [EXP_W-1:0]     w_x_e, w_y_e, w_diff;
  logic [MAN_W-1:0]     w_x_f, w_y_f;
  logic [M-1:0]         w_my_full, w_my_sh, w_lost;

  always_comb begin
    w_a_ge    = {r_a1.e, r_a1.f} >= {r_b1.e, r_b1.f};
    w_x_s     = w_a_ge ? r_a1.s : r_b1.s;
    w_x_e     = w_a_ge ? r_a1.e : r_b1.e;
    w_x_f     = w_a_ge ? r_a1.f : r_b1.f;
    w_y_s     = w_a_ge ? r_b1.s : r_a1.s;
    w_y_e     = w_a_ge ? r_b1.e : r_a1.e;
    w_y_f     = w_a_ge ? r_b1.f : r_a1.f;
    w_diff    = w_x_e - w_y_e;
    w_my_full = {1'b1, w_y_f, 3'b000};
    w_my_sh   = w_my_full >> w_diff;
    w_lost    = w_my_full & ~({M{1'b1}} << w_diff);
    w_s2      = '0;
    w_s2.s    = w_x_s;
    w_s2.e    = {1'b0, w_x_e};
    w_s2.mx   = {1'b1, w_x_f, 3'b000};
    w_s2.sub  = w_x_s ^ w_y_s;
    if (int'(w_diff) >= M - 1) w_s2.my = {{(M-1){1'b0}}, 1'b1};
    else                       w_s2.my = {w_my_sh[M-1:1], w_my_sh[0] | (|w_lost)};
    if (r_a1.c == NAN || r_b1.c == NAN ||
        (r_a1.c == INF && r_b1.c == INF && r_a1.s != r_b1.s)) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b1, res: QNAN};
    end else if (r_a1.c == INF) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b0, res: {r_a1.s, r_a1.e, r_a1.f}};
    end else if (r_b1.c == INF) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b0, res: {r_b1.s, r_b1.e, r_b1.f}};
    end else if (r_a1.c == ZERO && r_b1.c == ZERO) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b0, res: {r_a1.s & r_b1.s, {(W-1){1'b0}}}};
    end else if (r_a1.c == ZERO) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b0, res: {r_b1.s, r_b1.e, r_b1.f}};
    end else if (r_b1.c == ZERO) begin
      w_s2.sp = '{en: 1'b1, nan: 1'b0, res: {r_a1.s, r_a1.e, r_a1.f}};
    end
  end

  // Stage 3: magnitude add or subtract; x >= y so the difference never goes negative.
  always_comb begin
    w_s3     = '0;
    w_s3.s   = r_s2.s;
    w_s3.e   = r_s2.e;
    w_s3.sp  = r_s2.sp;
    w_s3.sum = r_s2.sub ? ({1'b0, r_s2.mx} - {1'b0, r_s2.my})
                        : ({1'b0, r_s2.mx} + {1'b0, r_s2.my});
  end

  // Stage 4: normalise.
  logic [LZ_W-1:0] w_lz;
  logic [M-1:0]    w_norm;

  fp_lzc #(.WIDTH(M), .CW(LZ_W)) u_lzc (
    .i_data  (r_s3.sum[M-1:0]),
    .o_count (w_lz)
  );

  always_comb begin
    w_s4    = '0;
    w_s4.s  = r_s3.s;
    w_s4.e  = r_s3.e;
    w_s4.sp = r_s3.sp;
    w_norm  = r_s3.sum[M-1:0] << w_lz;
    if (r_s3.sum[M]) begin
      w_s4.n = {r_s3.sum[M:2], r_s3.sum[1] | r_s3.sum[0]};
      w_s4.e = r_s3.e + (EXP_W+1)'(1);
    end else if (r_s3.sum == '0) begin
      w_s4.zero = 1'b1;
      w_s4.s    = 1'b0;
    end else if (int'(w_lz) >= int'(r_s3.e)) begin
      w_s4.zero = 1'b1;
      w_s4.unf  = 1'b1;
    end else begin
      w_s4.n = w_norm;
      w_s4.e = r_s3.e - (EXP_W+1)'(w_lz);
    end
  end

  // Stage 5: round, renormalise on rounding carry, detect overflow, apply specials.
  logic               w_inc;
  logic [MAN_W+1:0]   w_rnd;
  logic [EXP_W:0]     w_e5;
  logic [MAN_W-1:0]   w_f5;
`ifndef FP_ROUND_RNE_EN
  logic [2:0]         w_unused_grs;
  assign w_unused_grs = r_s4.n[2:0];
`endif

  always_comb begin
`ifdef FP_ROUND_RNE_EN
    w_inc = r_s4.n[2] && (r_s4.n[1] || r_s4.n[0] || r_s4.n[3]);
`else
    w_inc = 1'b0;
`endif
    w_rnd  = {1'b0, r_s4.n[M-1:3]} + (MAN_W+2)'(w_inc);
    w_e5   = r_s4.e + (EXP_W+1)'(w_rnd[MAN_W+1]);
    w_f5   = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    w_res5 = '0;
    w_flg5 = '0;
    if (r_s4.sp.en) begin
      w_res5     = r_s4.sp.res;
      w_flg5.nan = r_s4.sp.nan;
    end else if (r_s4.zero) begin
      w_res5           = {r_s4.s, {(W-1){1'b0}}};
      w_flg5.underflow = r_s4.unf;
    end else if (w_e5 >= {1'b0, EXP_ONES}) begin
      w_flg5.overflow = 1'b1;
`ifdef FP_ROUND_RNE_EN
      w_res5 = {r_s4.s, EXP_ONES, {MAN_W{1'b0}}};
`else
      w_res5 = {r_s4.s, EXP_MAX, {MAN_W{1'b1}}};
`endif
    end else begin
      w_res5 = {r_s4.s, w_e5[EXP_W-1:0], w_f5};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n)     r_v <= '0;
    else if (w_adv) r_v <= {r_v[3:0], valid_in};
  end

  always_ff @(posedge clk_in) begin
    if (w_adv) begin
      r_a1   <= unpack(a, 1'b0);
      r_b1   <= unpack(b, op_sub);
      r_s2   <= w_s2;
      r_s3   <= w_s3;
      r_s4   <= w_s4;
      r_res5 <= w_res5;
      r_flg5 <= w_flg5;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary16 shape): directed vectors, random beats under
// backpressure, and a mid-stream reset. Expectations adapt to FP_ROUND_RNE_EN.
module tb_fp_addsub_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = EXP_W + MAN_W + 1;
  localparam int EW    = W + 3;
`ifdef FP_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         op_sub = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
  logic         ready_out, valid_out, busy;
  logic [W-1:0] result;
  logic [2:0]   flags;

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .result    (result),
    .flags     (flags),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            chk_lat = 1'b0, in_rst = 1'b1, rand_ready = 1'b0;
  bit            stall_prev = 1'b0;
  logic [EW-1:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: exact integer sum, then correct rounding of the exact value.
  function automatic logic [EW-1:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic sub);
    logic sx, sy, sgn, rnd_up;
    logic [4:0] ex, ey;
    logic [9:0] fx, fy;
    bit zx, zy, ix, iy, nx, ny;
    longint va, vb, s, mag, q, rem, half;
    int emin, p, e, sh;
    sx = x[15]; ex = x[14:10]; fx = x[9:0];
    sy = y[15] ^ sub; ey = y[14:10]; fy = y[9:0];
    zx = (ex == 0); ix = (ex == 31) && (fx == 0); nx = (ex == 31) && (fx != 0);
    zy = (ey == 0); iy = (ey == 31) && (fy == 0); ny = (ey == 31) && (fy != 0);
    if (nx || ny || (ix && iy && sx != sy)) return {3'b100, 16'h7E00};
    if (ix) return {3'b000, sx, ex, fx};
    if (iy) return {3'b000, sy, ey, fy};
    if (zx && zy) return {3'b000, sx & sy, 15'h0};
    if (zx) return {3'b000, sy, ey, fy};
    if (zy) return {3'b000, sx, ex, fx};
    emin = (ex < ey) ? int'(ex) : int'(ey);
    va = longint'({1'b1, fx}) << (int'(ex) - emin);
    vb = longint'({1'b1, fy}) << (int'(ey) - emin);
    s = (sx ? -va : va) + (sy ? -vb : vb);
    if (s == 0) return '0;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = emin + p - 10;
    if (e < 1) return {3'b001, sgn, 15'h0};
    if (p > 10) begin
      sh = p - 10;
      q = mag >> sh;
      rem = mag & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      rnd_up = (rem > half) || (rem == half && q[0]);
      if (RNE && rnd_up) q = q + 1;
    end else begin
      q = mag << (10 - p);
    end
    if (q == 2048) begin
      q = q >> 1;
      e++;
    end
    if (e >= 31) return RNE ? {3'b010, sgn, 5'h1F, 10'h000} : {3'b010, sgn, 5'h1E, 10'h3FF};
    return {3'b000, sgn, e[4:0], q[9:0]};
  endfunction

  // ---------------- monitor: pop/compare on consumed output beats ----------------
  always @(negedge clk_in) begin
    if (!in_rst) begin
      if (stall_prev && valid_out) check_eq("hold", {flags, result}, held);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_out", valid_out, 0);
        end else if (ready_in) begin
          check_eq("result", {flags, result}, exp_q.pop_front());
          if (chk_lat) check_eq("latency", cyc - lat_q.pop_front(), 5);
          else void'(lat_q.pop_front());
        end
      end else begin
        check_eq("idle_zero", {flags, result}, 0);
      end
      stall_prev = valid_out && !ready_in;
      held = {flags, result};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                      input logic [EW-1:0] expv);
    bit ok;
    a = ta; b = tb; op_sub = ts; valid_in = 1'b1;
    for (int guard = 0; guard < 200; guard++) begin
      @(negedge clk_in);
      ok = ready_out;
      if (ok) begin
        exp_q.push_back(expv);
        lat_q.push_back(cyc);
      end
      @(posedge clk_in);
      #1;
      if (ok) break;
      if (guard == 199) check_eq("send_timeout", ready_out, 1);
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk_in);
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return {1'($urandom_range(0, 1)), 5'h00, 10'($urandom_range(0, 1023))};
      1:       return {1'($urandom_range(0, 1)), 5'h1F, 10'h000};
      2:       return {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))};
      default: return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endcase
  endfunction

  // ---------------- directed table ----------------
  localparam int ND = 13;
  logic [15:0]   da[ND], db[ND];
  logic          ds[ND];
  logic [EW-1:0] de[ND];

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    da[0]  = 16'h3C00; db[0]  = 16'h4000; ds[0]  = 0; de[0]  = {3'b000, 16'h4200};
    da[1]  = 16'h3C00; db[1]  = 16'h3C00; ds[1]  = 1; de[1]  = {3'b000, 16'h0000};
    da[2]  = 16'h8000; db[2]  = 16'h8000; ds[2]  = 0; de[2]  = {3'b000, 16'h8000};
    da[3]  = 16'h4200; db[3]  = 16'h0000; ds[3]  = 0; de[3]  = {3'b000, 16'h4200};
    da[4]  = 16'h7BFF; db[4]  = 16'h7BFF; ds[4]  = 0; de[4]  = RNE ? {3'b010, 16'h7C00} : {3'b010, 16'h7BFF};
    da[5]  = 16'h3C00; db[5]  = 16'h1000; ds[5]  = 0; de[5]  = {3'b000, 16'h3C00};
    da[6]  = 16'h3C01; db[6]  = 16'h1000; ds[6]  = 0; de[6]  = RNE ? {3'b000, 16'h3C02} : {3'b000, 16'h3C01};
    da[7]  = 16'h7C00; db[7]  = 16'h7C00; ds[7]  = 1; de[7]  = {3'b100, 16'h7E00};
    da[8]  = 16'h7E01; db[8]  = 16'h3C00; ds[8]  = 0; de[8]  = {3'b100, 16'h7E00};
    da[9]  = 16'hFC00; db[9]  = 16'h4000; ds[9]  = 0; de[9]  = {3'b000, 16'hFC00};
    da[10] = 16'h0400; db[10] = 16'h0401; ds[10] = 1; de[10] = {3'b001, 16'h8000};
    da[11] = 16'h4000; db[11] = 16'hC000; ds[11] = 0; de[11] = {3'b000, 16'h0000};
    da[12] = 16'h0000; db[12] = 16'h8000; ds[12] = 0; de[12] = {3'b000, 16'h0000};

    // reset and post-reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    @(negedge clk_in);
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready_out", ready_out, 1);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    @(posedge clk_in);
    #1;
    in_rst = 1'b0;

    // directed, single beat first (clean latency), then back-to-back
    chk_lat = 1'b1;
    send(da[0], db[0], ds[0], de[0]);
    wait_drain();
    for (int i = 1; i < ND; i++) send(da[i], db[i], ds[i], de[i]);
    wait_drain();

    // random beats under backpressure
    chk_lat = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_op();
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_add(ra, rb, rs));
    end
    wait_drain();

    // reset in the middle of a stream
    for (int i = 0; i < 8; i++) begin
      ra = rand_op();
      rb = rand_op();
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_add(ra, rb, rs));
    end
    in_rst = 1'b1;
    rst_n = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk_in);
    #1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk_in);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid_out", valid_out, 0);
    check_eq("midrst_result", result, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    in_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      check_eq("post_rst_no_out", valid_out, 0);
    end
    @(posedge clk_in);
    #1;

    // pipe still works after reset
    chk_lat = 1'b1;
    send(16'h3C00, 16'h4000, 1'b0, {3'b000, 16'h4200});
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
